// File: rtl/imem_ctrl_pkg.sv
// Shared encodings and constants for the instruction-memory fetch controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package imem_ctrl_pkg;

  // Controller phase encoding
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Byte distance between consecutive instruction words
  localparam logic [31:0] PC_STEP = 32'd4;

  // Width of the saturating issue counter
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/imem_load_port.sv
// Loader handshake to instruction-memory write strobe during the boot phase.
// Latency: combinational; the write lands on the same cycle as valid&ready.
// Backpressure: ready only while booting; words offered outside boot are dropped.
module imem_load_port #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          boot_i,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata
);

  // Accept every offered word in boot; out-of-range indices never strobe the memory
  always_comb begin
    load_ready = boot_i;
    imem_we    = boot_i && load_valid && (32'(load_addr) < DEPTH);
    imem_waddr = load_addr;
    imem_wdata = load_data;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Boot-time program loader plus run-time PC/fetch sequencer for a 32-word imem.
// Latency: one cycle from imem_pc to if_instr; redirect flushes one fetch.
// Backpressure: stall holds PC and IF register; redirect overrides stall.
// Optional: IMEM_HALT_ON_ZERO_EN halts fetch on an all-zero instruction word.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [AW-1:0]    load_addr,
  input  logic [31:0]      load_data,
  input  logic             load_done,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_rdata,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [31:0]      imem_wdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             state_run,
  output logic [CNT_W-1:0] fetch_count
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             issue;

  // Target PCs are word aligned; the low bits of a redirect are discarded
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  imem_load_port #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_load_port (
    .boot_i     (state_q == ST_BOOT),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  // Phase sequencing and fetch decision: redirect > stall > advance
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    issue         = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if_valid_d = 1'b0;
        if (load_done) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = {redirect_pc[31:2], 2'b00};
          if_valid_d = 1'b0;
        end else if (!stall) begin
`ifdef IMEM_HALT_ON_ZERO_EN
          if (imem_rdata == 32'h0) begin
            // Zero word marks end of program: park PC on it and stop issuing
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
          end else begin
            issue = 1'b1;
          end
`else
          issue = 1'b1;
`endif
        end
      end
      ST_HALT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d    = ST_BOOT;
        pc_d       = RESET_PC;
        if_valid_d = 1'b0;
      end
    endcase
    if (issue) begin
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
      if (fetch_count_q != {CNT_W{1'b1}}) begin
        fetch_count_d = fetch_count_q + 1'b1;
      end
    end
  end

  // State, PC and IF register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= 32'h0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_pc     = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign state_run   = (state_q == ST_RUN);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 32-word memory.
// Latency: checks registered outputs #1 after each rising edge.
// Backpressure: exercises stall, redirect-over-stall and dropped loads in RUN.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic [31:0] imem_pc;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        state_run;
  logic [15:0] fetch_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read by word index
  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign imem_rdata = mem[imem_pc[6:2]];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_done      (load_done),
    .imem_pc        (imem_pc),
    .imem_rdata     (imem_rdata),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .state_run      (state_run),
    .fetch_count    (fetch_count)
  );

  // Program image: add/sub/add/sub then addi $8,$0,k
  function automatic logic [31:0] word_of(input int k);
    case (k)
      0:       return 32'h0232_8020;
      1:       return 32'h0232_8022;
      2:       return 32'h0109_5020;
      3:       return 32'h0109_5022;
      default: return 32'h2008_0000 | 32'(k);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_state_run", 32'(state_run), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);

    // Load all 32 words
    for (int k = 0; k < 32; k++) begin
      load_valid = 1'b1; load_addr = 5'(k); load_data = word_of(k);
      #1;
      if (k == 0) begin
        chk("boot_we", 32'(imem_we), 32'd1);
        chk("boot_wdata", imem_wdata, 32'h0232_8020);
      end
      tick();
    end
    load_valid = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("run_entered", 32'(state_run), 32'd1);
    chk("run_imem_pc", imem_pc, 32'h0);
    chk("run_if_valid0", 32'(if_valid), 32'd0);
    chk("run_load_ready", 32'(load_ready), 32'd0);

    tick();
    chk("f0_valid", 32'(if_valid), 32'd1);
    chk("f0_pc", if_pc, 32'h0);
    chk("f0_instr", if_instr, 32'h0232_8020);
    tick();
    chk("f1_pc", if_pc, 32'h4);

    // Stall three cycles at if_pc=4
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h0232_8022);
      chk("stall_count", 32'(fetch_count), 32'd2);
      chk("stall_imem_pc", imem_pc, 32'h8);
    end
    stall = 1'b0;
    tick();
    chk("resume_pc", if_pc, 32'h8);
    chk("resume_instr", if_instr, 32'h0109_5020);
    tick();
    chk("count4", 32'(fetch_count), 32'd4);

    // Redirect beats stall; low bits of target discarded
    redirect_valid = 1'b1; redirect_pc = 32'h17; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_flush", 32'(if_valid), 32'd0);
    chk("redir_imem_pc", imem_pc, 32'h14);
    chk("redir_count", 32'(fetch_count), 32'd4);
    tick();
    chk("redir_if_pc", if_pc, 32'h14);
    chk("redir_instr", if_instr, word_of(5));

    // Wrap past the last word
    redirect_valid = 1'b1; redirect_pc = 32'h7C;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc7c", if_pc, 32'h7C);
    chk("wrap_instr31", if_instr, word_of(31));
    tick();
    chk("wrap_pc80", if_pc, 32'h80);
    chk("wrap_instr0", if_instr, 32'h0232_8020);
    chk("wrap_imem_pc", imem_pc, 32'h84);
    chk("wrap_count", 32'(fetch_count), 32'd7);

    // Loader attempt in RUN is dropped, then reset mid-run
    load_valid = 1'b1; load_addr = 5'd3; load_data = 32'hDEAD_BEEF;
    #1;
    chk("run_load_we", 32'(imem_we), 32'd0);
    chk("run_load_rdy", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_state_run", 32'(state_run), 32'd0);
    chk("mrst_if_valid", 32'(if_valid), 32'd0);
    chk("mrst_count", 32'(fetch_count), 32'd0);
    chk("mrst_load_ready", 32'(load_ready), 32'd1);
    chk("mrst_imem_pc", imem_pc, 32'h0);

    // Zero word at index 7, written in the same cycle as load_done
    load_valid = 1'b1; load_addr = 5'd7; load_data = 32'h0; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    chk("b2_run", 32'(state_run), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) begin
        chk("b2_pc_c", if_pc, 32'hC);
        chk("b2_word3_kept", if_instr, 32'h0109_5022);
      end
`ifdef IMEM_HALT_ON_ZERO_EN
      if (i == 7) chk("halt_last_pc", if_pc, 32'h18);
`else
      if (i == 8) begin
        chk("zero_pc", if_pc, 32'h1C);
        chk("zero_instr", if_instr, 32'h0);
        chk("zero_valid", 32'(if_valid), 32'd1);
      end
`endif
    end
`ifdef IMEM_HALT_ON_ZERO_EN
    chk("halt_valid", 32'(if_valid), 32'd0);
    chk("halt_count", 32'(fetch_count), 32'd7);
    chk("halt_state_run", 32'(state_run), 32'd0);
    chk("halt_imem_pc", imem_pc, 32'h1C);
`else
    chk("nohalt_count", 32'(fetch_count), 32'd10);
    chk("nohalt_state_run", 32'(state_run), 32'd1);
    chk("nohalt_imem_pc", imem_pc, 32'h28);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
